// File: rtl/invntt_unload.sv
// Inverse-NTT output stage: streams the result RAM in address order, scales each
// coefficient by F and Barrett-reduces it mod Q through a 4-stage stall-able pipeline.
module invntt_unload #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned Q      = 3329,
  parameter int unsigned F      = 1441,
  parameter int unsigned BK     = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set,
  input  logic              done,
  output logic              full_out,
  output logic              rd_en,
  output logic [DEPTH-1:0]  rd_addr,
  input  logic [COEF_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned BM  = (1 << BK) / Q;
  localparam int unsigned PW  = COEF_W + $clog2(F + 1);
  localparam int unsigned BMW = $clog2(BM + 1);
  localparam int unsigned MW  = PW + BMW;
  localparam int unsigned TW  = MW - BK;
  localparam int unsigned RW  = COEF_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FULL} state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   addr_q, addr_d;
  logic               v1_q, v1_d, last1_q, last1_d;
  logic               v2_q, v2_d, last2_q, last2_d;
  logic [PW-1:0]      p2_q, p2_d;
  logic               v3_q, v3_d, last3_q, last3_d;
  logic [PW-1:0]      p3_q, p3_d;
  logic [TW-1:0]      t3_q, t3_d;
  logic               ov_q, ov_d, ol_q, ol_d;
  logic [COEF_W-1:0]  od_q, od_d;

  logic               adv, en, rd_en_c;
  logic [MW-1:0]      prod;
  logic [RW-1:0]      r_w;

  always_comb begin
    adv     = !ov_q || out_ready;
    en      = set && adv;
    state_d = state_q;
    addr_d  = addr_q;
    rd_en_c = 1'b0;
    unique case (state_q)
      IDLE:  if (done) state_d = RUN;
      RUN: begin
        if (adv) begin
          rd_en_c = 1'b1;
          addr_d  = addr_q + DEPTH'(1);
          if (addr_q == '1) state_d = DRAIN;
        end
      end
      DRAIN: if (ov_q && out_ready && ol_q) state_d = FULL;
      FULL:  if (!done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // set=0 freezes the FSM too; the read strobe must drop or the RAM would
    // overwrite data the frozen pipeline has not yet consumed.
    if (!set) begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_en_c = 1'b0;
    end
  end

  always_comb begin
    prod = MW'(p2_q) * MW'(BM);
    r_w  = RW'(p3_q - (PW'(t3_q) * PW'(Q)));

    v1_d    = v1_q;    last1_d = last1_q;
    v2_d    = v2_q;    last2_d = last2_q;  p2_d = p2_q;
    v3_d    = v3_q;    last3_d = last3_q;  p3_d = p3_q;  t3_d = t3_q;
    ov_d    = ov_q;    ol_d    = ol_q;     od_d = od_q;
    if (en) begin
      v1_d    = rd_en_c;
      last1_d = rd_en_c && (addr_q == '1);
      v2_d    = v1_q;
      last2_d = last1_q;
      p2_d    = PW'(rd_data) * PW'(F);
      v3_d    = v2_q;
      last3_d = last2_q;
      p3_d    = p2_q;
      t3_d    = TW'(prod >> BK);
      ov_d    = v3_q;
      ol_d    = last3_q;
      od_d    = (r_w >= RW'(Q)) ? COEF_W'(r_w - RW'(Q)) : r_w[COEF_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      v1_q    <= 1'b0;  last1_q <= 1'b0;
      v2_q    <= 1'b0;  last2_q <= 1'b0;  p2_q <= '0;
      v3_q    <= 1'b0;  last3_q <= 1'b0;  p3_q <= '0;  t3_q <= '0;
      ov_q    <= 1'b0;  ol_q    <= 1'b0;  od_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      v1_q    <= v1_d;  last1_q <= last1_d;
      v2_q    <= v2_d;  last2_q <= last2_d;  p2_q <= p2_d;
      v3_q    <= v3_d;  last3_q <= last3_d;  p3_q <= p3_d;  t3_q <= t3_d;
      ov_q    <= ov_d;  ol_q    <= ol_d;     od_q <= od_d;
    end
  end

  assign full_out  = (state_q == FULL);
  assign rd_en     = rd_en_c;
  assign rd_addr   = addr_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;

endmodule

// File: tb/tb_invntt_unload.sv
// Bench for invntt_unload: RAM model, scoreboard of (x*F)%Q per issued read,
// vector table for edge values, and sequences for stall, freeze and reset.
module tb_invntt_unload;
  localparam int N = 256;
  localparam int Q = 3329;
  localparam int F = 1441;

  logic        clk = 1'b0;
  logic        reset_n, set, done, out_ready;
  logic        full_out, rd_en, out_valid, out_last;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data, out_data;
  logic [11:0] mem [N];

  int checks = 0;
  int failures = 0;
  int beats = 0;
  int exp_addr = 0;
  int got [N];

  typedef struct {logic [11:0] data; logic last;} exp_t;
  exp_t sbq [$];

  typedef struct {int addr; int x; int exp;} vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;

  invntt_unload #(.DEPTH(8), .COEF_W(12), .Q(3329), .F(1441), .BK(24)) dut (
    .clk(clk), .reset_n(reset_n), .set(set), .done(done), .full_out(full_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic int model(input int x);
    return (x * F) % Q;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_rd_en"}, int'(rd_en), 0);
    check({pfx, "_rd_addr"}, int'(rd_addr), 0);
    check({pfx, "_out_valid"}, int'(out_valid), 0);
    check({pfx, "_out_data"}, int'(out_data), 0);
    check({pfx, "_out_last"}, int'(out_last), 0);
    check({pfx, "_full_out"}, int'(full_out), 0);
  endtask

  // Scoreboard: push on each issued read, pop on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sbq.delete();
      exp_addr = 0;
    end else begin
      if (rd_en) begin
        check("rd_addr_order", int'(rd_addr), exp_addr % N);
        e.data = 12'(model(int'(mem[exp_addr % N])));
        e.last = (exp_addr % N) == N - 1;
        sbq.push_back(e);
        exp_addr++;
      end
      if (set && out_valid && out_ready) begin
        check("beat_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("out_data", int'(out_data), int'(e.data));
          check("out_last", int'(out_last), int'(e.last));
        end
        if (beats < N) got[beats] = int'(out_data);
        beats++;
      end
    end
  end

  task automatic stream(input bit rnd, input int stall_at, input int freeze_at,
                        input int rst_beat, input bit timing);
    int first_v, last_v, full_c, first_rd, last_rd, nrd;
    logic [11:0] hd;
    logic [7:0]  ha;
    logic [22:0] snap;
    bit fin;
    beats = 0; exp_addr = 0; sbq.delete();
    first_v = -1; last_v = -1; full_c = -1; first_rd = -1; last_rd = -1; nrd = 0; fin = 0;
    hd = '0; ha = '0; snap = '0;
    done = 1'b1; set = 1'b1; out_ready = 1'b1;
    tick();
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10) out_ready = 1'b0;
      set = !(freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + 5);
      #1;
      if (rst_beat >= 0 && beats >= rst_beat) begin
        done = 1'b0;
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_idle_rd_en", int'(rd_en), 0);
        check("post_rst_idle_full", int'(full_out), 0);
        return;
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        nrd++;
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_last) last_v = cyc;
      if (full_out) begin
        full_c = cyc;
        fin = 1'b1;
        check("beats_at_full", beats, N);
      end
      if (stall_at >= 0 && cyc == stall_at) begin
        hd = out_data;
        ha = rd_addr;
        check("stall_valid", int'(out_valid), 1);
      end
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10) begin
        check("stall_rd_en", int'(rd_en), 0);
        check("stall_rd_addr", int'(rd_addr), int'(ha));
        check("stall_out_data", int'(out_data), int'(hd));
      end
      if (freeze_at >= 0 && cyc == freeze_at)
        snap = {out_valid, out_last, full_out, out_data, rd_addr};
      if (freeze_at >= 0 && cyc > freeze_at && cyc <= freeze_at + 5)
        check("freeze_outputs", int'({out_valid, out_last, full_out, out_data, rd_addr}), int'(snap));
      if (freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + 5)
        check("freeze_rd_en", int'(rd_en), 0);
      if (!fin) tick();
    end
    check("full_reached", int'(fin), 1);
    check("sb_empty", sbq.size(), 0);
    if (!fin) begin
      done = 1'b0; reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
      return;
    end
    if (timing) begin
      check("first_rd_cycle", first_rd, 0);
      check("last_rd_cycle", last_rd, N - 1);
      check("rd_count", nrd, N);
      check("first_valid_cycle", first_v, 4);
      check("last_beat_cycle", last_v, N + 3);
      check("full_cycle", full_c, N + 4);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check("full_hold", int'(full_out), 1);
      check("no_rearm", int'(rd_en), 0);
    end
    done = 1'b0;
    #1;
    check("full_until_edge", int'(full_out), 1);
    tick();
    check("full_drop", int'(full_out), 0);
  endtask

  initial begin
    vecs = '{'{0, 0, 0}, '{1, 1, 1441}, '{2, 2, 2882}, '{3, 3, 994}, '{4, 3328, 1888},
             '{5, 4095, 1907}, '{6, 3329, 0}, '{7, 1664, 944}, '{255, 4095, 1907}};
    reset_n = 1'b0; set = 1'b1; done = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = 12'(i);
    tick(); tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) mem[vecs[i].addr] = 12'(vecs[i].x);
    stream(1'b0, -1, -1, -1, 1'b1);
    foreach (vecs[i]) check("vec_table", got[vecs[i].addr], vecs[i].exp);

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < N; i++) mem[i] = 12'(k * N + i);
      stream(1'(k % 2), -1, -1, -1, 1'b0);
    end

    for (int i = 0; i < N; i++) mem[i] = 12'($urandom_range(0, 4095));
    stream(1'b0, 50, -1, -1, 1'b0);
    stream(1'b0, -1, 20, -1, 1'b0);
    stream(1'b0, -1, -1, 100, 1'b0);
    stream(1'b1, -1, -1, -1, 1'b0);
    check("final_beats", beats, N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
